// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: multiplexes Masters request ports onto a single APB requester command port.
// Define APB_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module apb_req_arbiter #(
  parameter int Masters   = 4,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int Slaves    = 4,
  localparam int StrbWidth = DataWidth / 8,
  localparam int SelWidth  = (Slaves > 1) ? $clog2(Slaves) : 1,
  localparam int MIdx      = $clog2(Masters)
) (
  input  logic                           PCLK,
  input  logic                           reset_n,
  input  logic [Masters-1:0]             Req,
  input  logic [Masters-1:0]             RdWr,
  input  logic [Masters*AddrWidth-1:0]   MAddr,
  input  logic [Masters*SelWidth-1:0]    MSel,
  input  logic [Masters*DataWidth-1:0]   MWData,
  input  logic [Masters*StrbWidth-1:0]   MStrb,
  output logic [Masters-1:0]             Gnt,
  output logic [Masters-1:0]             Done,
  output logic [DataWidth-1:0]           RData,
  output logic                           Start,
  output logic                           RD,
  output logic                           WR,
  output logic [AddrWidth-1:0]           Addr,
  output logic [SelWidth-1:0]            Sel,
  output logic [DataWidth-1:0]           SendData,
  output logic [StrbWidth-1:0]           Strb,
  input  logic                           Busy,
  input  logic [DataWidth-1:0]           DataReceived,
  output logic [1:0]                     ArbState
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [MIdx:0] MCount = (MIdx+1)'(Masters);

  logic [1:0]      state;
  logic [MIdx-1:0] win_idx;
  logic            win_valid;
  logic [MIdx:0]   cand;
  logic [MIdx-1:0] ptr;
  logic            rdwr_q;

  // Handshake: Start is a one-cycle command strobe with fields valid; the requester then holds
  // Busy high until the APB access completes; Done pulses one cycle with RData valid.

`ifdef APB_ARB_RR_EN
  logic [MIdx-1:0] gnt_idx;

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      if (state == IDLE && win_valid)
        gnt_idx <= win_idx;
      if (state == DONE)
        ptr <= (gnt_idx == MIdx'(Masters-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // Search starts at ptr and wraps; with ptr fixed at 0 this is plain lowest-index priority.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < Masters; k++) begin
      cand = {1'b0, ptr} + (MIdx+1)'(k);
      if (cand >= MCount)
        cand = cand - MCount;
      if (!win_valid && Req[cand[MIdx-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[MIdx-1:0];
      end
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      Gnt      <= '0;
      Done     <= '0;
      RData    <= '0;
      rdwr_q   <= 1'b0;
      Addr     <= '0;
      Sel      <= '0;
      SendData <= '0;
      Strb     <= '0;
    end else begin
      Done <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            Gnt      <= {{(Masters-1){1'b0}}, 1'b1} << win_idx;
            rdwr_q   <= RdWr[win_idx];
            Addr     <= MAddr[win_idx*AddrWidth +: AddrWidth];
            Sel      <= MSel[win_idx*SelWidth +: SelWidth];
            SendData <= MWData[win_idx*DataWidth +: DataWidth];
            Strb     <= MStrb[win_idx*StrbWidth +: StrbWidth];
            state    <= ISSUE;
          end
        end
        ISSUE: state <= ACTIVE;
        ACTIVE: begin
          if (!Busy) begin
            RData <= DataReceived;
            Done  <= Gnt;
            state <= DONE;
          end
        end
        DONE: begin
          Gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Start    = (state == ISSUE);
  assign RD       = Start & ~rdwr_q;
  assign WR       = Start & rdwr_q;
  assign ArbState = state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a simple requester model (Busy for setup+access+waits).
module tb_apb_req_arbiter;
  localparam int M  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 2;
  localparam int BW = 4;

  logic              PCLK = 1'b0;
  logic              reset_n;
  logic [M-1:0]      Req, RdWr, Gnt, Done;
  logic [M*AW-1:0]   MAddr;
  logic [M*SW-1:0]   MSel;
  logic [M*DW-1:0]   MWData;
  logic [M*BW-1:0]   MStrb;
  logic [DW-1:0]     RData, SendData, DataReceived;
  logic              Start, RD, WR, Busy;
  logic [AW-1:0]     Addr;
  logic [SW-1:0]     Sel;
  logic [BW-1:0]     Strb;
  logic [1:0]        ArbState;

  apb_req_arbiter dut (
    .PCLK(PCLK), .reset_n(reset_n), .Req(Req), .RdWr(RdWr), .MAddr(MAddr), .MSel(MSel),
    .MWData(MWData), .MStrb(MStrb), .Gnt(Gnt), .Done(Done), .RData(RData), .Start(Start),
    .RD(RD), .WR(WR), .Addr(Addr), .Sel(Sel), .SendData(SendData), .Strb(Strb),
    .Busy(Busy), .DataReceived(DataReceived), .ArbState(ArbState)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  // requester model: Busy rises after Start, stays high for 2 + wait_states cycles
  int wait_states;
  int busy_cnt;
  always @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      Busy     <= 1'b0;
      busy_cnt <= 0;
    end else if (Start) begin
      Busy     <= 1'b1;
      busy_cnt <= 1 + wait_states;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      Busy <= 1'b0;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [M-1:0]  gnt_log[$], done_log[$];
  logic          rd_log[$], wr_log[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] sd_log[$], rdata_log[$];
  int            start_cyc_log[$], done_cyc_log[$];
  logic          stable_ok;
  int            spurious;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); done_log.delete(); rd_log.delete(); wr_log.delete();
    addr_log.delete(); sd_log.delete(); rdata_log.delete();
    start_cyc_log.delete(); done_cyc_log.delete();
    stable_ok = 1'b1;
    spurious  = 0;
  endtask

  // driver tasks
  task automatic set_master(input int i, input logic rw, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic [DW-1:0] d, input logic [BW-1:0] b);
    RdWr[i]            = rw;
    MAddr[i*AW +: AW]  = a;
    MSel[i*SW +: SW]   = s;
    MWData[i*DW +: DW] = d;
    MStrb[i*BW +: BW]  = b;
  endtask

  // Observe a fixed number of cycles (cycle 1 = first negedge after the sampling edge).
  task automatic watch(input int cycles, input bit drop);
    logic [M-1:0]  g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit inflight;
    g = '0; a = '0; d = '0; inflight = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge PCLK);
      if (!Start && (RD || WR)) spurious++;
      if (Start) begin
        gnt_log.push_back(Gnt); rd_log.push_back(RD); wr_log.push_back(WR);
        addr_log.push_back(Addr); sd_log.push_back(SendData); start_cyc_log.push_back(c);
        g = Gnt; a = Addr; d = SendData; inflight = 1'b1;
        if (drop) begin
          Req    = '0;
          MAddr  = ~MAddr;
          MWData = ~MWData;
        end
      end else if (inflight) begin
        if (Gnt !== g || Addr !== a || SendData !== d) stable_ok = 1'b0;
      end
      if (Done != '0) begin
        done_log.push_back(Done); done_cyc_log.push_back(c); rdata_log.push_back(RData);
        inflight = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    reset_n = 1'b0;
    Req     = '0;
    repeat (2) @(negedge PCLK);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; Req = '0; RdWr = '0; MAddr = '0; MSel = '0; MWData = '0; MStrb = '0;
    DataReceived = '0; wait_states = 0;
    clear_logs();
    repeat (3) @(negedge PCLK);
    check("rst_gnt", 32'(Gnt), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_start", 32'({Start, RD, WR}), 0);
    check("rst_rdata", RData, 0);
    check("rst_state", 32'(ArbState), 0);
    reset_n = 1'b1;

    // single zero-wait read by master 2
    @(negedge PCLK);
    set_master(2, 1'b0, 32'h0000_0040, 2'd1, 32'h0, 4'h0);
    DataReceived = 32'hDEAD_BEEF; wait_states = 0; Req = 4'b0100;
    clear_logs(); watch(10, 1'b1);
    check("rd_nstart", gnt_log.size(), 1);
    check("rd_gnt", 32'(gnt_log[0]), 32'h4);
    check("rd_rdflag", 32'({rd_log[0], wr_log[0]}), 32'b10);
    check("rd_addr", addr_log[0], 32'h40);
    check("rd_start_cyc", start_cyc_log[0], 1);
    check("rd_ndone", done_log.size(), 1);
    check("rd_done", 32'(done_log[0]), 32'h4);
    check("rd_done_cyc", done_cyc_log[0], 5);
    check("rd_rdata", rdata_log[0], 32'hDEAD_BEEF);
    check("rd_stable", 32'(stable_ok), 1);

    // write by master 1 with three wait states
    set_master(1, 1'b1, 32'h0000_2000, 2'd2, 32'h1234_5678, 4'hF);
    DataReceived = 32'hCAFE_0002; wait_states = 3; Req = 4'b0010;
    clear_logs(); watch(14, 1'b1);
    check("wr_nstart", gnt_log.size(), 1);
    check("wr_gnt", 32'(gnt_log[0]), 32'h2);
    check("wr_wrflag", 32'({rd_log[0], wr_log[0]}), 32'b01);
    check("wr_senddata", sd_log[0], 32'h1234_5678);
    check("wr_ndone", done_log.size(), 1);
    check("wr_done", 32'(done_log[0]), 32'h2);
    check("wr_done_cyc", done_cyc_log[0], 8);
    check("wr_rdata", rdata_log[0], 32'hCAFE_0002);
    check("wr_stable", 32'(stable_ok), 1);
    check("wr_spurious", spurious, 0);

    // reset during ACTIVE, then first arbitration must favour master 0
    set_master(2, 1'b0, 32'h0000_0080, 2'd3, 32'h0, 4'h0);
    wait_states = 5; Req = 4'b0100;
    clear_logs(); watch(3, 1'b1);
    check("mid_state", 32'(ArbState), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_gnt", 32'(Gnt), 0);
    check("mid_start", 32'(Start), 0);
    check("mid_done", 32'(Done), 0);
    check("mid_addr", Addr, 0);
    check("mid_rdata", RData, 0);
    repeat (2) @(negedge PCLK);
    reset_n = 1'b1;
    wait_states = 0; DataReceived = 32'h0000_0101;
    set_master(0, 1'b0, 32'h0000_0010, 2'd0, 32'h0, 4'h0);
    set_master(3, 1'b0, 32'h0000_0030, 2'd3, 32'h0, 4'h0);
    Req = 4'b1001;
    clear_logs(); watch(12, 1'b1);
    check("post_first_gnt", 32'(gnt_log[0]), 32'h1);
    check("post_first_ndone", done_log.size(), 1);
    check("post_first_done", 32'(done_log[0]), 32'h1);
    set_master(3, 1'b0, 32'h0000_0030, 2'd3, 32'h0, 4'h0);
    Req = 4'b1000;
    clear_logs(); watch(12, 1'b1);
    check("post_m3_gnt", 32'(gnt_log[0]), 32'h8);
    check("post_m3_ndone", done_log.size(), 1);
    check("post_m3_done", 32'(done_log[0]), 32'h8);

    // master 0 drops Req and scrambles its fields during ISSUE
    set_master(0, 1'b0, 32'h0000_0100, 2'd0, 32'h0, 4'h0);
    DataReceived = 32'hA5A5_0001; wait_states = 1; Req = 4'b0001;
    clear_logs(); watch(12, 1'b1);
    check("drop_gnt", 32'(gnt_log[0]), 32'h1);
    check("drop_addr", addr_log[0], 32'h100);
    check("drop_ndone", done_log.size(), 1);
    check("drop_done", 32'(done_log[0]), 32'h1);
    check("drop_done_cyc", done_cyc_log[0], 6);
    check("drop_rdata", rdata_log[0], 32'hA5A5_0001);
    check("drop_stable", 32'(stable_ok), 1);

    // contention with Req held
    apply_reset();
    wait_states = 0;
    clear_logs();
`ifdef APB_ARB_RR_EN
    Req = 4'b1111;
    exp_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
`else
    Req = 4'b1010;
    exp_q = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2};
`endif
    watch(30, 1'b0);
    Req = '0;
    watch(8, 1'b0);
    check("cont_ngrants", gnt_log.size(), 5);
    check("cont_ndone", done_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("cont_gnt%0d", i), 32'(gnt_log[i]), e);
      check($sformatf("cont_done%0d", i), 32'(done_log[i]), e);
    end
    check("cont_spurious", spurious, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
